// File: rtl/ecc_ram_pkg.sv
// ---------------------------------------------------------------------------
// ecc_ram_pkg
//   Shared definitions for the operand RAM controller: controller state
//   encoding and the helper that sizes the host beat counter.
// ---------------------------------------------------------------------------
package ecc_ram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_H_WR = 2'd1,
        ST_H_RD = 2'd2,
        ST_CORE = 2'd3
    } state_t;

    // Width of a counter indexing BEATS host beats (never narrower than 1).
    function automatic int unsigned beat_cnt_w(input int unsigned beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/ecc_ram_dp.sv
// ---------------------------------------------------------------------------
// ecc_ram_dp
//   True dual-port synchronous RAM, DEPTH = 2**ADDR_W words of DATA_W bits.
//   Both ports read-before-write with registered read data; read registers
//   only update when their port is enabled, so data holds otherwise.
//   Array contents are not reset; only the read registers are.
//
// Ports
//   i_clk, i_rst_n                   clock, async active-low reset
//   i_a_en/i_a_we/i_a_addr/i_a_wdata port A (host side) controls
//   o_a_rdata                        port A registered read data
//   i_b_en/i_b_we/i_b_addr/i_b_wdata port B (core side) controls
//   o_b_rdata                        port B registered read data
// ---------------------------------------------------------------------------
module ecc_ram_dp #(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_a_en,
    input  logic              i_a_we,
    input  logic [ADDR_W-1:0] i_a_addr,
    input  logic [DATA_W-1:0] i_a_wdata,
    output logic [DATA_W-1:0] o_a_rdata,
    input  logic              i_b_en,
    input  logic              i_b_we,
    input  logic [ADDR_W-1:0] i_b_addr,
    input  logic [DATA_W-1:0] i_b_wdata,
    output logic [DATA_W-1:0] o_b_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    // Both write ports share one process; the controller never enables
    // both ports in the same cycle, so ordering here is immaterial.
    always_ff @(posedge i_clk) begin
        if (i_a_en && i_a_we) r_mem[i_a_addr] <= i_a_wdata;
        if (i_b_en && i_b_we) r_mem[i_b_addr] <= i_b_wdata;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_a_rdata <= '0;
            o_b_rdata <= '0;
        end else begin
            if (i_a_en) o_a_rdata <= r_mem[i_a_addr];
            if (i_b_en) o_b_rdata <= r_mem[i_b_addr];
        end
    end

endmodule

// File: rtl/operand_ram_ctrl.sv
// ---------------------------------------------------------------------------
// operand_ram_ctrl
//   Arbitrates a DATA_W-wide operand RAM between a narrow host interface
//   (HOST_W beats, BEATS = DATA_W/HOST_W per word) and a full-width core.
//   IDLE priority: core request > host write > host read.
//
// Ports
//   clk, rst_n              clock, async active-low reset
//   h_wr_valid/h_wr_ready   host write beat handshake
//   h_addr                  host word address (latched on first beat/read req)
//   h_wdata                 host write beat
//   h_rd_req                single-cycle host read request
//   h_rd_valid/h_rdata      host read beats, least-significant first
//   c_req/c_gnt/c_done      core ownership handshake
//   c_we/c_addr/c_wdata     core full-width access
//   c_rdata                 core registered read data (holds outside CORE)
//   busy                    controller not idle
// ---------------------------------------------------------------------------
module operand_ram_ctrl
    import ecc_ram_pkg::*;
#(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned HOST_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              h_wr_valid,
    output logic              h_wr_ready,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [HOST_W-1:0] h_wdata,
    input  logic              h_rd_req,
    output logic              h_rd_valid,
    output logic [HOST_W-1:0] h_rdata,
    input  logic              c_req,
    output logic              c_gnt,
    input  logic              c_done,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic [DATA_W-1:0] c_rdata,
    output logic              busy
);

    localparam int unsigned BEATS = DATA_W / HOST_W;
    localparam int unsigned CNT_W = beat_cnt_w(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    if (DATA_W % HOST_W != 0) begin : g_width_check
        $error("operand_ram_ctrl: DATA_W must be a multiple of HOST_W");
    end

    state_t            r_state;
    state_t            w_nxt_state;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_beat;
    logic              r_rd_fetched;
    logic [DATA_W-1:0] r_wbuf;

    logic              w_a_en;
    logic              w_a_we;
    logic [ADDR_W-1:0] w_a_addr;
    logic [DATA_W-1:0] w_wr_word;
    logic [DATA_W-1:0] w_a_rdata;
    logic              w_b_en;

    // Partial word with the current beat merged in; r_beat is 0 in IDLE,
    // so the first beat (or the only beat when BEATS=1) lands in slice 0.
    always_comb begin
        w_wr_word = r_wbuf;
        for (int unsigned k = 0; k < BEATS; k++) begin
            if (r_beat == CNT_W'(k)) w_wr_word[k*HOST_W +: HOST_W] = h_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_nxt_state;
    end

    always_comb begin
        w_nxt_state = r_state;
        h_wr_ready  = 1'b0;
        h_rd_valid  = 1'b0;
        c_gnt       = 1'b0;
        w_a_en      = 1'b0;
        w_a_we      = 1'b0;
        w_a_addr    = r_addr;
        w_b_en      = 1'b0;
        busy        = (r_state != ST_IDLE);
        unique case (r_state)
            ST_IDLE: begin
                h_wr_ready = !c_req;
                w_a_addr   = h_addr;
                if (c_req) begin
                    w_nxt_state = ST_CORE;
                end else if (h_wr_valid) begin
                    if (BEATS == 1) begin
                        w_a_en = 1'b1;
                        w_a_we = 1'b1;
                    end else begin
                        w_nxt_state = ST_H_WR;
                    end
                end else if (h_rd_req) begin
                    w_nxt_state = ST_H_RD;
                end
            end
            ST_H_WR: begin
                h_wr_ready = 1'b1;
                if (h_wr_valid && (r_beat == LAST_BEAT)) begin
                    w_a_en      = 1'b1;
                    w_a_we      = 1'b1;
                    w_nxt_state = ST_IDLE;
                end
            end
            ST_H_RD: begin
                // First cycle fetches the word; the port then stays disabled
                // so its registered output holds while beats stream out.
                if (!r_rd_fetched) begin
                    w_a_en = 1'b1;
                end else begin
                    h_rd_valid = 1'b1;
                    if (r_beat == LAST_BEAT) w_nxt_state = ST_IDLE;
                end
            end
            ST_CORE: begin
                c_gnt  = 1'b1;
                w_b_en = 1'b1;
                if (c_done) w_nxt_state = ST_IDLE;
            end
            default: w_nxt_state = ST_IDLE;
        endcase
    end

    always_comb begin
        h_rdata = '0;
        for (int unsigned k = 0; k < BEATS; k++) begin
            if (h_rd_valid && (r_beat == CNT_W'(k))) h_rdata = w_a_rdata[k*HOST_W +: HOST_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr       <= '0;
            r_beat       <= '0;
            r_rd_fetched <= 1'b0;
            r_wbuf       <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_beat       <= '0;
                    r_rd_fetched <= 1'b0;
                    if (w_nxt_state == ST_H_WR) begin
                        r_addr <= h_addr;
                        r_wbuf <= w_wr_word;
                        r_beat <= CNT_W'(1);
                    end else if (w_nxt_state == ST_H_RD) begin
                        r_addr <= h_addr;
                    end
                end
                ST_H_WR: begin
                    if (h_wr_valid) begin
                        r_wbuf <= w_wr_word;
                        r_beat <= (r_beat == LAST_BEAT) ? '0 : r_beat + 1'b1;
                    end
                end
                ST_H_RD: begin
                    if (!r_rd_fetched) r_rd_fetched <= 1'b1;
                    else               r_beat <= (r_beat == LAST_BEAT) ? '0 : r_beat + 1'b1;
                end
                default: ;
            endcase
        end
    end

    ecc_ram_dp #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_a_en    (w_a_en),
        .i_a_we    (w_a_we),
        .i_a_addr  (w_a_addr),
        .i_a_wdata (w_wr_word),
        .o_a_rdata (w_a_rdata),
        .i_b_en    (w_b_en),
        .i_b_we    (c_we),
        .i_b_addr  (c_addr),
        .i_b_wdata (c_wdata),
        .o_b_rdata (c_rdata)
    );

endmodule

// File: doc/operand_ram_ctrl.md
OPERAND_RAM_CTRL -- requirements
Module: operand_ram_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 256, giving the operand word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, giving the address width; DEPTH = 2**ADDR_W words.
REQ-003 The block SHALL have parameter HOST_W, default 32, giving the host beat width; BEATS = DATA_W/HOST_W.
REQ-004 The block SHALL have the following ports:
- clk  in  1  single clock; all logic rises on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- h_wr_valid  in  1  host write beat valid.
- h_wr_ready  out  1  host write beat accepted when high with h_wr_valid.
- h_addr  in  ADDR_W  host operand address; sampled on first write beat or on h_rd_req.
- h_wdata  in  HOST_W  host write beat data.
- h_rd_req  in  1  single-cycle host read request.
- h_rd_valid  out  1  host read beat valid.
- h_rdata  out  HOST_W  host read beat data.
- c_req  in  1  core requests RAM ownership.
- c_gnt  out  1  core owns RAM.
- c_done  in  1  core releases RAM.
- c_we  in  1  core full-width write enable.
- c_addr  in  ADDR_W  core address.
- c_wdata  in  DATA_W  core write data.
- c_rdata  out  DATA_W  core read data.
- busy  out  1  high whenever state is not IDLE.

Function
REQ-005 Storage SHALL be DEPTH words of DATA_W bits, with contents unaffected by reset.
REQ-006 The FSM SHALL have states IDLE, H_WR, H_RD and CORE.
REQ-007 IDLE priority SHALL be c_req > h_wr_valid > h_rd_req; a losing request SHALL be ignored that cycle, and h_wr_ready SHALL be 0 in IDLE while c_req=1.
REQ-008 IDLE with c_req=1 SHALL move to CORE next cycle; c_gnt SHALL be 1 exactly while in CORE.
REQ-009 In CORE, c_we=1 SHALL write c_wdata to mem[c_addr] at the clock edge.
REQ-010 In CORE, c_rdata SHALL equal mem[c_addr] registered one cycle later, read-before-write; c_rdata SHALL hold its value outside CORE.
REQ-011 c_done=1 in CORE SHALL return the FSM to IDLE next cycle; a c_we in the same cycle SHALL still be performed.
REQ-012 c_we and c_done SHALL be ignored outside CORE.
REQ-013 Host write beats:
- A beat is accepted when h_wr_valid & h_wr_ready.
- h_wr_ready SHALL be 1 in H_WR and in IDLE when c_req=0, and 0 otherwise.
- The first beat latches h_addr and enters H_WR.
- Beat k fills bits [k*HOST_W +: HOST_W], least-significant first.
REQ-014 On the BEATS-th accepted beat, the assembled word SHALL be written to RAM at that edge and the FSM SHALL return to IDLE.
REQ-015 With BEATS=1, a write beat SHALL be written directly and the FSM SHALL stay in IDLE.
REQ-016 h_wr_valid low during H_WR SHALL stall assembly without timeout.
REQ-017 Host reads:
- Accepted h_rd_req latches h_addr and enters H_RD.
- The RAM read takes 1 cycle.
- h_rd_valid is then 1 for BEATS consecutive cycles, presenting words least-significant first.
- There is no backpressure.
- After the last beat the FSM returns to IDLE.
- h_rd_req is ignored outside IDLE.
REQ-018 Read latency SHALL be 2 cycles from h_rd_req to the first h_rd_valid.
REQ-019 A core request arriving during H_WR or H_RD SHALL wait; c_gnt SHALL rise at most 1 cycle after the host operation returns to IDLE.
REQ-020 If DATA_W is not a multiple of HOST_W, elaboration SHALL fail.

Reset
REQ-021 While rst_n=0 the FSM SHALL be IDLE; c_gnt, busy and h_rd_valid SHALL be 0; h_rdata, c_rdata and the beat counter SHALL be 0.
REQ-022 Reset mid-H_WR SHALL discard the partial word with no RAM write; reset mid-H_RD SHALL drop the remaining beats.

Structure
REQ-023 State encoding and a BEATS-width helper constant SHALL reside in shared package ecc_ram_pkg.
REQ-024 Storage SHALL be one sub-module ecc_ram_dp: a true dual-port synchronous RAM with registered reads, port A for host, port B for core, parametrised by DATA_W and ADDR_W.

Verification (DATA_W=256, ADDR_W=5, HOST_W=32, BEATS=8)
REQ-025 Write 8 beats 0x11111111..0x88888888 to addr 3, then read addr 3 -> h_rdata 0x11111111..0x88888888 on 8 consecutive valid cycles, first at +2 cycles.
REQ-026 c_req=1 and h_wr_valid=1 in the same IDLE cycle -> c_gnt=1 next cycle, h_wr_ready=0, no host beat accepted.
REQ-027 Core writes 0xAB..AB to addr 7 and reads addr 7 in the same cycle -> old value returned, next read returns 0xAB..AB; c_done -> c_gnt=0 and busy=0 next cycle.
REQ-028 rst_n low after 5 of 8 write beats to addr 2 -> addr 2 unchanged on readback, FSM IDLE, h_wr_ready=1.
REQ-029 c_req asserted during H_RD beat 4 -> c_gnt=1 no earlier than the cycle after beat 8, within 1 cycle of returning to IDLE.
